dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data RAM between two requesters: the pipeline MEM-stage port and a debug/loader port. The debug port is used for program load, memory inspection and test poking.
- The pipeline has priority.
- The debug port has a bounded-wait starvation guard; when it fires, the pipeline is stalled for exactly one cycle.
- Sits between the EX/MEM pipeline register and the RAM array. It drives the RAM control signals and returns read data with valid flags to both requesters.

Parameters:
ADDR_SIZE, 10, RAM word-address width (depth 2**ADDR_SIZE)
WORD_SIZE, 32, data width
MAX_WAIT, 4, consecutive cycles a pending debug request may lose before it is forced through; 0 = debug always wins

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pipe_req  in  1  pipeline requests RAM access this cycle
pipe_we  in  1  1 = write, 0 = read
pipe_addr  in  ADDR_SIZE  pipeline word address
pipe_wdata  in  WORD_SIZE  pipeline write data
pipe_stall  out  1  pipeline request not served this cycle; pipeline must hold
pipe_rvalid  out  1  pipe_rdata valid (one cycle after a granted pipeline read)
pipe_rdata  out  WORD_SIZE  read data to pipeline
dbg_valid  in  1  debug request pending; held with stable fields until accepted
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_SIZE  debug word address
dbg_wdata  in  WORD_SIZE  debug write data
dbg_ready  out  1  debug request accepted this cycle (valid && ready = transfer)
dbg_rvalid  out  1  dbg_rdata valid (one cycle after an accepted debug read)
dbg_rdata  out  WORD_SIZE  read data to debug
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_SIZE  RAM address
ram_wdata  out  WORD_SIZE  RAM write data
ram_rdata  in  WORD_SIZE  RAM read data, registered inside RAM, valid one cycle after ram_en && !ram_we

Behaviour:
- Reset (async, rst_n=0): wait_cnt=0, state=ARB, pipe_rvalid=0, dbg_rvalid=0. All combinational outputs evaluate to 0 with no requests. Any read in flight when reset asserts is discarded; no rvalid is issued for it.
- States:
  - ARB: normal arbitration.
  - FORCE: starvation guard active.
- Grant rules:
  - Let force = (state==FORCE) || (MAX_WAIT==0).
  - gnt_dbg = dbg_valid && (force || !pipe_req).
  - gnt_pipe = pipe_req && !gnt_dbg.
  - At most one grant per cycle.
- Combinational outputs, same cycle as the request (zero-latency grant):
  - pipe_stall = pipe_req && !gnt_pipe.
  - dbg_ready = gnt_dbg.
  - ram_en = gnt_pipe || gnt_dbg.
  - ram_we / ram_addr / ram_wdata come from the granted requester; all 0 when nothing is granted.
- Read return:
  - pipe_rvalid <= gnt_pipe && !pipe_we.
  - dbg_rvalid <= gnt_dbg && !dbg_we.
  - pipe_rdata = dbg_rdata = ram_rdata, passed through; consumers qualify with their rvalid.
  - Back-to-back reads are allowed: one per cycle, in order.
- Starvation counter wait_cnt (width clog2(MAX_WAIT+1), saturating):
  - Cleared when dbg_valid=0 or gnt_dbg=1.
  - Otherwise increments.
- FSM transitions:
  - ARB -> FORCE when dbg_valid && !gnt_dbg && wait_cnt == MAX_WAIT-1.
  - FORCE -> ARB unconditionally after one cycle.
  - In FORCE the debug request is always granted, because dbg_valid must stay high until accepted.
  - If dbg_valid drops in FORCE (protocol violation), no grant is made and the FSM still returns to ARB.
- Result: with continuous pipe_req, a debug request is served no later than MAX_WAIT+1 cycles after dbg_valid rises. The pipeline loses exactly one cycle per forced grant.
- Same-address conflicts are serialised by the grant order. A read granted after a write in a prior cycle returns the new data.
- The address is a word index; range is the caller's concern and wraps at 2**ADDR_SIZE by truncation. No GPIO decode in this block.

Decomposition:
- Shared package: state encoding (ARB, FORCE) and a clog2 constant function for the wait_cnt width.
- No sub-module needed. Grant logic, counter, FSM and rvalid flops live in one module (~150 lines).
- The RAM array stays in its own existing module. The bench uses a behavioural 1-cycle-latency RAM model.

Test Plan:
- Pipe-only read: preload mem[5]=32'hDEADBEEF, pipe_req=1, pipe_we=0, pipe_addr=5 for one cycle -> pipe_stall=0 that cycle; next cycle pipe_rvalid=1, pipe_rdata=32'hDEADBEEF; dbg_rvalid stays 0.
- Idle debug write: pipe_req=0, dbg_valid=1, dbg_we=1, dbg_addr=3, dbg_wdata=32'h12345678 -> same cycle dbg_ready=1, ram_en=1, ram_we=1, ram_addr=3; a subsequent pipe read of 3 returns 32'h12345678.
- Starvation (MAX_WAIT=4): pipe_req held high, dbg_valid (read) raised at cycle 0 -> dbg_ready=0 on cycles 0-3, pipe_stall=0 on cycles 0-3; cycle 4 dbg_ready=1, pipe_stall=1; cycle 5 dbg_rvalid=1, pipe_stall=0.
- Back-to-back reads: pipe reads addresses 1,2,3 on consecutive cycles with dbg_valid=0 -> pipe_rvalid high for 3 consecutive cycles, data in order mem[1], mem[2], mem[3].
- Reset mid-read: debug read granted, rst_n pulled low before the next clock edge -> dbg_rvalid=0 immediately and after release; wait_cnt=0; state=ARB.
- MAX_WAIT=0 build: pipe_req=1 and dbg_valid=1 together -> dbg_ready=1, pipe_stall=1 in the same cycle, every cycle dbg_valid is held.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the arbiter state encoding and the starvation-counter width function.
// No logic; imported by dmem_arbiter.
package dmem_arbiter_pkg;

  // ARB: normal pipeline-priority arbitration; FORCE: debug request is pushed through.
  typedef enum logic {
    ARB   = 1'b0,
    FORCE = 1'b1
  } arb_state_e;

  // Bits needed to hold values 0..max_wait; never less than one bit so the
  // counter stays declarable when max_wait is 0.
  function automatic int cnt_width(input int max_wait);
    int w;
    w = 1;
    while ((1 << w) < (max_wait + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Purpose: shares the single-port data RAM between the pipeline MEM port and a debug port.
// Latency: zero-cycle grant/stall; read data returns one cycle after a granted read.
// Backpressure: pipeline held with pipe_stall; debug held until dbg_ready (guard forces it after MAX_WAIT losses).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 32,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_req,
  input  logic                 pipe_we,
  input  logic [ADDR_SIZE-1:0] pipe_addr,
  input  logic [WORD_SIZE-1:0] pipe_wdata,
  output logic                 pipe_stall,
  output logic                 pipe_rvalid,
  output logic [WORD_SIZE-1:0] pipe_rdata,
  input  logic                 dbg_valid,
  input  logic                 dbg_we,
  input  logic [ADDR_SIZE-1:0] dbg_addr,
  input  logic [WORD_SIZE-1:0] dbg_wdata,
  output logic                 dbg_ready,
  output logic                 dbg_rvalid,
  output logic [WORD_SIZE-1:0] dbg_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  input  logic [WORD_SIZE-1:0] ram_rdata
);

  localparam int             CW         = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0]  CNT_MAX    = CW'(MAX_WAIT);
  localparam logic [CW-1:0]  CNT_LAST   = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;
  localparam logic           ALWAYS_DBG = (MAX_WAIT == 0);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          pipe_rvalid_q, pipe_rvalid_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;
  logic          force_dbg;
  logic          gnt_dbg;
  logic          gnt_pipe;

  // Grant decision: pipeline wins unless the guard is active or the pipeline is idle.
  always_comb begin
    force_dbg = (state_q == FORCE) || ALWAYS_DBG;
    gnt_dbg   = dbg_valid && (force_dbg || !pipe_req);
    gnt_pipe  = pipe_req && !gnt_dbg;
  end

  // Requester handshakes and RAM command mux; everything idles at zero without a grant.
  always_comb begin
    pipe_stall = pipe_req && !gnt_pipe;
    dbg_ready  = gnt_dbg;
    ram_en     = gnt_pipe || gnt_dbg;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (gnt_dbg) begin
      ram_we    = dbg_we;
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
    end else if (gnt_pipe) begin
      ram_we    = pipe_we;
      ram_addr  = pipe_addr;
      ram_wdata = pipe_wdata;
    end
  end

  // Next state: starvation counter, guard FSM and read-return flags.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    pipe_rvalid_d = gnt_pipe && !pipe_we;
    dbg_rvalid_d  = gnt_dbg && !dbg_we;

    if (!dbg_valid || gnt_dbg) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    case (state_q)
      ARB: begin
        if (dbg_valid && !gnt_dbg && (wait_cnt_q == CNT_LAST)) begin
          state_d = FORCE;
        end
      end
      // One forced cycle only; a dropped dbg_valid simply yields no grant.
      FORCE:   state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // State registers; reset discards any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB;
      wait_cnt_q    <= '0;
      pipe_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      pipe_rvalid_q <= pipe_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
    end
  end

  // Read data is shared; each consumer qualifies it with its own rvalid.
  always_comb begin
    pipe_rvalid = pipe_rvalid_q;
    dbg_rvalid  = dbg_rvalid_q;
    pipe_rdata  = ram_rdata;
    dbg_rdata   = ram_rdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vectors with a read-data scoreboard.
// Uses a behavioural one-cycle-latency RAM; a second instance covers MAX_WAIT=0.
// Expected read data is queued at issue and popped by an independent monitor.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        pipe_req, pipe_we;
  logic [9:0]  pipe_addr;
  logic [31:0] pipe_wdata;
  logic        pipe_stall, pipe_rvalid;
  logic [31:0] pipe_rdata;
  logic        dbg_valid, dbg_we;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ready, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  // second instance, MAX_WAIT = 0
  logic        p2_req, d2_valid;
  logic        p2_stall, p2_rvalid, d2_ready, d2_rvalid;
  logic [31:0] p2_rdata, d2_rdata, r2_wdata;
  logic        r2_en, r2_we;
  logic [9:0]  r2_addr;

  logic [31:0] mem [0:1023];
  logic [31:0] pipe_q[$];
  logic [31:0] dbg_q[$];
  int n_tests;
  int n_fail;

  dmem_arbiter #(.ADDR_SIZE(10), .WORD_SIZE(32), .MAX_WAIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall), .pipe_rvalid(pipe_rvalid), .pipe_rdata(pipe_rdata),
    .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  dmem_arbiter #(.ADDR_SIZE(10), .WORD_SIZE(32), .MAX_WAIT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .pipe_req(p2_req), .pipe_we(1'b0), .pipe_addr(10'd7), .pipe_wdata(32'h0),
    .pipe_stall(p2_stall), .pipe_rvalid(p2_rvalid), .pipe_rdata(p2_rdata),
    .dbg_valid(d2_valid), .dbg_we(1'b0), .dbg_addr(10'd9), .dbg_wdata(32'h0),
    .dbg_ready(d2_ready), .dbg_rvalid(d2_rvalid), .dbg_rdata(d2_rdata),
    .ram_en(r2_en), .ram_we(r2_we), .ram_addr(r2_addr), .ram_wdata(r2_wdata),
    .ram_rdata(32'h0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: one-cycle read latency; known contents loaded while in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[1] <= 32'hA1A1A1A1;
      mem[2] <= 32'hB2B2B2B2;
      mem[3] <= 32'hC3C3C3C3;
      mem[5] <= 32'hDEADBEEF;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (pipe_rvalid) begin
      if (pipe_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL pipe_rvalid_unexpected: got rvalid=1 data=%h expected no read at %0t", pipe_rdata, $time);
      end else begin
        check("pipe_rdata", pipe_rdata, pipe_q.pop_front());
      end
    end
    if (dbg_rvalid) begin
      if (dbg_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dbg_rvalid_unexpected: got rvalid=1 data=%h expected no read at %0t", dbg_rdata, $time);
      end else begin
        check("dbg_rdata", dbg_rdata, dbg_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_req = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_wdata = '0;
    dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic pipe_read(input logic [9:0] a);
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = a;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    p2_req = 1'b0; d2_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    // reset state
    check("rst_pipe_rvalid", 32'(pipe_rvalid), 32'd0);
    check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    check("rst_state", 32'(u_dut.state_q), 32'(ARB));
    check("rst_wait_cnt", 32'(u_dut.wait_cnt_q), 32'd0);
    rst_n = 1'b1;
    tick();
    #3;
    check("idle_pipe_stall", 32'(pipe_stall), 32'd0);
    check("idle_dbg_ready", 32'(dbg_ready), 32'd0);
    check("idle_ram_en", 32'(ram_en), 32'd0);
    check("idle_ram_we", 32'(ram_we), 32'd0);
    check("idle_ram_addr", 32'(ram_addr), 32'd0);
    check("idle_ram_wdata", ram_wdata, 32'd0);

    // pipe-only read of mem[5]
    tick();
    pipe_read(10'd5);
    #3;
    check("p_read_stall", 32'(pipe_stall), 32'd0);
    check("p_read_ram_en", 32'(ram_en), 32'd1);
    check("p_read_ram_addr", 32'(ram_addr), 32'd5);
    pipe_q.push_back(32'hDEADBEEF);

    // back-to-back reads 1,2,3
    tick();
    pipe_read(10'd1);
    #3;
    check("b2b_rvalid_0", 32'(pipe_rvalid), 32'd1);
    pipe_q.push_back(32'hA1A1A1A1);
    tick();
    pipe_read(10'd2);
    #3;
    check("b2b_rvalid_1", 32'(pipe_rvalid), 32'd1);
    pipe_q.push_back(32'hB2B2B2B2);
    tick();
    pipe_read(10'd3);
    #3;
    check("b2b_rvalid_2", 32'(pipe_rvalid), 32'd1);
    pipe_q.push_back(32'hC3C3C3C3);
    tick();
    idle();
    #3;
    check("b2b_rvalid_3", 32'(pipe_rvalid), 32'd1);
    check("b2b_dbg_rvalid", 32'(dbg_rvalid), 32'd0);

    // debug write with idle pipeline, then pipeline reads it back
    tick();
    dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd3; dbg_wdata = 32'h12345678;
    #3;
    check("dw_ready", 32'(dbg_ready), 32'd1);
    check("dw_ram_en", 32'(ram_en), 32'd1);
    check("dw_ram_we", 32'(ram_we), 32'd1);
    check("dw_ram_addr", 32'(ram_addr), 32'd3);
    check("dw_ram_wdata", ram_wdata, 32'h12345678);
    tick();
    idle();
    pipe_read(10'd3);
    #3;
    check("dw_readback_stall", 32'(pipe_stall), 32'd0);
    pipe_q.push_back(32'h12345678);

    // starvation guard: pipe_req held, debug read pending from cycle 0
    tick();
    pipe_read(10'd5);
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd3;
    for (int c = 0; c < 4; c++) begin
      #3;
      check($sformatf("starve_dbg_ready_c%0d", c), 32'(dbg_ready), 32'd0);
      check($sformatf("starve_pipe_stall_c%0d", c), 32'(pipe_stall), 32'd0);
      pipe_q.push_back(32'hDEADBEEF);
      tick();
    end
    #3;
    check("starve_dbg_ready_c4", 32'(dbg_ready), 32'd1);
    check("starve_pipe_stall_c4", 32'(pipe_stall), 32'd1);
    check("starve_ram_addr_c4", 32'(ram_addr), 32'd3);
    dbg_q.push_back(32'h12345678);
    tick();
    dbg_valid = 1'b0;
    #3;
    check("starve_pipe_stall_c5", 32'(pipe_stall), 32'd0);
    check("starve_dbg_rvalid_c5", 32'(dbg_rvalid), 32'd1);
    check("starve_state_c5", 32'(u_dut.state_q), 32'(ARB));
    pipe_q.push_back(32'hDEADBEEF);

    // reset mid-read: build up wait_cnt, then grant a debug read and reset before the edge
    tick();
    pipe_read(10'd5);
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd5;
    pipe_q.push_back(32'hDEADBEEF);
    tick();
    pipe_q.push_back(32'hDEADBEEF);
    tick();
    pipe_req = 1'b0;
    #3;
    check("mr_wait_cnt_pre", 32'(u_dut.wait_cnt_q), 32'd2);
    check("mr_dbg_ready", 32'(dbg_ready), 32'd1);
    #4;
    rst_n = 1'b0;
    #1;
    check("mr_wait_cnt_rst", 32'(u_dut.wait_cnt_q), 32'd0);
    check("mr_state_rst", 32'(u_dut.state_q), 32'(ARB));
    @(posedge clk); #1;
    idle();
    check("mr_dbg_rvalid_in_rst", 32'(dbg_rvalid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mr_dbg_rvalid_after", 32'(dbg_rvalid), 32'd0);
    check("mr_state_after", 32'(u_dut.state_q), 32'(ARB));
    check("mr_wait_cnt_after", 32'(u_dut.wait_cnt_q), 32'd0);

    // MAX_WAIT = 0 instance: debug always wins
    p2_req = 1'b1; d2_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3;
      check($sformatf("mw0_dbg_ready_c%0d", c), 32'(d2_ready), 32'd1);
      check($sformatf("mw0_pipe_stall_c%0d", c), 32'(p2_stall), 32'd1);
      tick();
    end
    d2_valid = 1'b0;
    #3;
    check("mw0_pipe_free", 32'(p2_stall), 32'd0);
    check("mw0_dbg_idle", 32'(d2_ready), 32'd0);
    p2_req = 1'b0;

    // drain: every queued read must have been returned within this budget
    repeat (4) tick();
    check("pipe_q_drained", 32'(pipe_q.size()), 32'd0);
    check("dbg_q_drained", 32'(dbg_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
